// File: rtl/wb_spi_master.sv
// ---------------------------------------------------------------------------
// wb_spi_master
//
// SPI master engine with a small Wishbone slave for TX/RX data and manual
// chip-select. Serialises 1-4 bytes per transfer, MSB first, in any of the
// four SPI modes. The prescaler, mode, auto-CS and size come from the SoC
// register block and are latched when a transfer starts.
//
// Ports
//   clk_i, rst_in            system clock, asynchronous active-low reset
//   wb_spi_*                 Wishbone slave (adr 0 = DATA, adr 1 = CSCTRL);
//                            ack is combinational cyc & stb
//   spi_presc_i              half-period = presc+1 clk cycles
//   spi_cpol_i, spi_cpha_i   SPI mode
//   spi_auto_cs_i            1: CS follows each transfer, 0: CSCTRL.cs drives CS
//   spi_size_i               transfer length = size+1 bytes
//   spi_rdy_o                1 while idle (a new transfer may start)
//   spi_sck_o, spi_mosi_o,
//   spi_cs_on, spi_miso_i    SPI pins (CS active low)
//
// Configuration
//   SPI_MASTER_LOOPBACK_EN   when defined, CSCTRL bit1 selects internal
//                            loopback (received data = spi_mosi_o).
// ---------------------------------------------------------------------------
module wb_spi_master (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        wb_spi_cyc_i,
    input  logic        wb_spi_stb_i,
    input  logic        wb_spi_we_i,
    output logic        wb_spi_ack_o,
    input  logic        wb_spi_adr_i,
    input  logic [3:0]  wb_spi_be_i,
    input  logic [31:0] wb_spi_dat_i,
    output logic [31:0] wb_spi_dat_o,
    input  logic [3:0]  spi_presc_i,
    input  logic        spi_cpol_i,
    input  logic        spi_cpha_i,
    input  logic        spi_auto_cs_i,
    input  logic [1:0]  spi_size_i,
    output logic        spi_rdy_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    output logic        spi_cs_on,
    input  logic        spi_miso_i
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  presc_q, div_cnt_q;
    logic        cpha_q, auto_cs_q;
    logic [1:0]  size_q;
    logic [31:0] tx_sh_q, rx_sh_q, rx_q;
    logic [4:0]  bit_cnt_q;
    logic        phase_q;       // 0: next SCK toggle is the leading edge
    logic        sck_q, mosi_q, cs_q, lb_q;

    logic        wb_req, start, csctrl_wr, tick, last_bit, sample, auto_eff;
    logic [31:0] tx_aligned;
    logic        unused_be;

    assign wb_req    = wb_spi_cyc_i & wb_spi_stb_i;
    assign start     = wb_req & wb_spi_we_i & ~wb_spi_adr_i & (state_q == IDLE);
    assign csctrl_wr = wb_req & wb_spi_we_i & wb_spi_adr_i & wb_spi_be_i[0];
    assign tick      = (div_cnt_q == presc_q);
    assign last_bit  = (bit_cnt_q == {size_q, 3'b111});
    assign unused_be = ^wb_spi_be_i[3:1];

    // Move bit 8N-1 of the write data to bit 31 so the shifter always
    // transmits from the top regardless of transfer size.
    assign tx_aligned = wb_spi_dat_i << {~spi_size_i, 3'b000};

`ifdef SPI_MASTER_LOOPBACK_EN
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in)        lb_q <= 1'b0;
        else if (csctrl_wr) lb_q <= wb_spi_dat_i[1];
    end
    assign sample = lb_q ? mosi_q : spi_miso_i;
`else
    assign lb_q   = 1'b0;
    assign sample = spi_miso_i;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps paths that
        // do not assign it from inferring a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (tick) state_d = SHIFT;
            SHIFT:   if (tick && phase_q && last_bit) state_d = HOLD;
            HOLD:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            // NOTE: non-blocking assignments for all registered state, so every
            // register samples pre-edge values regardless of statement order.
            presc_q   <= '0;
            div_cnt_q <= '0;
            cpha_q    <= 1'b0;
            auto_cs_q <= 1'b0;
            size_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            if (csctrl_wr) cs_q <= wb_spi_dat_i[0];

            if (state_q == IDLE || tick) div_cnt_q <= '0;
            else                         div_cnt_q <= div_cnt_q + 4'd1;

            case (state_q)
                IDLE: begin
                    sck_q <= spi_cpol_i;
                    if (start) begin
                        presc_q   <= spi_presc_i;
                        cpha_q    <= spi_cpha_i;
                        auto_cs_q <= spi_auto_cs_i;
                        size_q    <= spi_size_i;
                        rx_sh_q   <= '0;
                        bit_cnt_q <= '0;
                        phase_q   <= 1'b0;
                        if (!spi_cpha_i) begin
                            // CPHA=0 presents the first bit before any edge.
                            mosi_q  <= tx_aligned[31];
                            tx_sh_q <= tx_aligned << 1;
                        end else begin
                            tx_sh_q <= tx_aligned;
                        end
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sck_q   <= ~sck_q;
                        phase_q <= ~phase_q;
                        // Leading edge samples for CPHA=0, drives for CPHA=1;
                        // the trailing edge does the opposite.
                        if (phase_q == cpha_q) begin
                            rx_sh_q <= {rx_sh_q[30:0], sample};
                        end else begin
                            mosi_q  <= tx_sh_q[31];
                            tx_sh_q <= tx_sh_q << 1;
                        end
                        if (phase_q && !last_bit) bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                HOLD: begin
                    if (tick) rx_q <= rx_sh_q;
                end
                default: ;
            endcase
        end
    end

    // In IDLE the live auto-CS input decides who owns CS; during a transfer
    // the latched copy does.
    assign auto_eff = (state_q == IDLE) ? spi_auto_cs_i : auto_cs_q;

    assign wb_spi_ack_o = wb_req;
    assign wb_spi_dat_o = wb_spi_adr_i ? {30'b0, lb_q, cs_q} : rx_q;
    assign spi_rdy_o    = (state_q == IDLE);
    assign spi_sck_o    = sck_q;
    assign spi_mosi_o   = mosi_q;
    assign spi_cs_on    = auto_eff ? (state_q == IDLE) : ~cs_q;

endmodule

// File: tb/tb_wb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_wb_spi_master
//
// Directed self-checking bench for wb_spi_master. A small SPI slave model
// either returns a preset byte MSB first (mode 0), echoes MOSI, or ties MISO
// low. SCK rising edges are counted and MOSI is captured on them.
// ---------------------------------------------------------------------------
module tb_wb_spi_master;

    logic        clk_i = 1'b0;
    logic        rst_in = 1'b0;
    logic        wb_spi_cyc_i = 1'b0, wb_spi_stb_i = 1'b0, wb_spi_we_i = 1'b0;
    logic        wb_spi_ack_o;
    logic        wb_spi_adr_i = 1'b0;
    logic [3:0]  wb_spi_be_i = 4'h0;
    logic [31:0] wb_spi_dat_i = '0;
    logic [31:0] wb_spi_dat_o;
    logic [3:0]  spi_presc_i = 4'd0;
    logic        spi_cpol_i = 1'b0, spi_cpha_i = 1'b0;
    logic        spi_auto_cs_i = 1'b1;
    logic [1:0]  spi_size_i = 2'd0;
    logic        spi_rdy_o, spi_sck_o, spi_mosi_o, spi_cs_on;
    logic        spi_miso_i;

    wb_spi_master dut (
        .clk_i         (clk_i),
        .rst_in        (rst_in),
        .wb_spi_cyc_i  (wb_spi_cyc_i),
        .wb_spi_stb_i  (wb_spi_stb_i),
        .wb_spi_we_i   (wb_spi_we_i),
        .wb_spi_ack_o  (wb_spi_ack_o),
        .wb_spi_adr_i  (wb_spi_adr_i),
        .wb_spi_be_i   (wb_spi_be_i),
        .wb_spi_dat_i  (wb_spi_dat_i),
        .wb_spi_dat_o  (wb_spi_dat_o),
        .spi_presc_i   (spi_presc_i),
        .spi_cpol_i    (spi_cpol_i),
        .spi_cpha_i    (spi_cpha_i),
        .spi_auto_cs_i (spi_auto_cs_i),
        .spi_size_i    (spi_size_i),
        .spi_rdy_o     (spi_rdy_o),
        .spi_sck_o     (spi_sck_o),
        .spi_mosi_o    (spi_mosi_o),
        .spi_cs_on     (spi_cs_on),
        .spi_miso_i    (spi_miso_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- slave model and monitors ----------------
    int unsigned neg_cnt = 0, pos_cnt = 0, cs_rise_cnt = 0, neg_base = 0;
    logic [31:0] mosi_cap = '0;
    logic [7:0]  miso_byte = 8'h00;
    int          miso_sel = 0;   // 0: byte model, 1: echo MOSI, 2: tied low
    logic [2:0]  miso_idx;

    always @(negedge spi_sck_o) neg_cnt <= neg_cnt + 1;
    always @(posedge spi_sck_o) begin
        pos_cnt  <= pos_cnt + 1;
        mosi_cap <= {mosi_cap[30:0], spi_mosi_o};
    end
    always @(posedge spi_cs_on) cs_rise_cnt <= cs_rise_cnt + 1;

    assign miso_idx   = 3'd7 - 3'(neg_cnt - neg_base);
    assign spi_miso_i = (miso_sel == 1) ? spi_mosi_o :
                        (miso_sel == 2) ? 1'b0 : miso_byte[miso_idx];

    // ---------------- checking ----------------
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic adr, input logic [3:0] be, input logic [31:0] dat);
        wb_spi_cyc_i = 1'b1; wb_spi_stb_i = 1'b1; wb_spi_we_i = 1'b1;
        wb_spi_adr_i = adr; wb_spi_be_i = be; wb_spi_dat_i = dat;
        #1 check("write ack", {31'b0, wb_spi_ack_o}, 32'd1);
        @(posedge clk_i);
        #1;
        wb_spi_cyc_i = 1'b0; wb_spi_stb_i = 1'b0; wb_spi_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic adr, output logic [31:0] data);
        wb_spi_cyc_i = 1'b1; wb_spi_stb_i = 1'b1; wb_spi_we_i = 1'b0;
        wb_spi_adr_i = adr;
        #1 data = wb_spi_dat_o;
        wb_spi_cyc_i = 1'b0; wb_spi_stb_i = 1'b0;
    endtask

    // Counts cycles with rdy low, sampled on falling clock edges; bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (spi_rdy_o) break;
            cycles++;
        end
        check("rdy returns", {31'b0, spi_rdy_o}, 32'd1);
    endtask

    task automatic do_xfer(input logic [31:0] dat, input logic [7:0] miso,
                           output int cycles, output int pulses);
        int unsigned p0;
        miso_byte = miso;
        neg_base  = neg_cnt;
        p0        = pos_cnt;
        wb_write(1'b0, 4'h0, dat);
        wait_idle(cycles);
        pulses = int'(pos_cnt - p0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        int cyc, pul, extra;
        int unsigned p0, r0;

        repeat (3) @(negedge clk_i);
        rst_in = 1'b1;
        @(negedge clk_i);
        check("reset rdy",  {31'b0, spi_rdy_o},  32'd1);
        check("reset sck",  {31'b0, spi_sck_o},  32'd0);
        check("reset mosi", {31'b0, spi_mosi_o}, 32'd0);
        check("reset cs",   {31'b0, spi_cs_on},  32'd1);
        wb_read(1'b0, rd); check("reset DATA", rd, 32'h0);
        wb_read(1'b1, rd); check("reset CSCTRL", rd, 32'h0);

        // Mode 0, presc 0, 1 byte: (16+2)*1 = 18 busy cycles
        @(negedge clk_i);
        do_xfer(32'h0000_00A5, 8'h3C, cyc, pul);
        check("m0 busy cycles", cyc, 32'd18);
        check("m0 pulses", pul, 32'd8);
        wb_read(1'b0, rd); check("m0 DATA", rd, 32'h0000_003C);
        // back-to-back: write in the first rdy=1 cycle
        do_xfer(32'hFFFF_FF81, 8'h7E, cyc, pul);
        check("b2b busy cycles", cyc, 32'd18);
        check("b2b pulses", pul, 32'd8);
        check("b2b mosi", {24'b0, mosi_cap[7:0]}, 32'h81);
        check("b2b sck idle", {31'b0, spi_sck_o}, 32'd0);
        check("b2b cs idle", {31'b0, spi_cs_on}, 32'd1);
        wb_read(1'b0, rd); check("b2b DATA", rd, 32'h0000_007E);

        // Mode 3, presc 3, 4 bytes, echo slave: (64+2)*4 = 264 cycles.
        // Config inputs change mid-transfer and must be ignored.
        spi_cpol_i = 1'b1; spi_cpha_i = 1'b1; spi_presc_i = 4'd3; spi_size_i = 2'd3;
        miso_sel = 1;
        repeat (2) @(negedge clk_i);
        check("m3 idle sck", {31'b0, spi_sck_o}, 32'd1);
        p0 = pos_cnt;
        wb_write(1'b0, 4'h0, 32'h1234_5678);
        repeat (10) @(negedge clk_i);
        check("m3 cs asserted", {31'b0, spi_cs_on}, 32'd0);
        spi_presc_i = 4'd0; spi_size_i = 2'd0; spi_cpha_i = 1'b0;
        wait_idle(cyc);
        check("m3 busy cycles", 32'(10 + cyc), 32'd264);
        check("m3 pulses", 32'(pos_cnt - p0), 32'd32);
        check("m3 mosi", mosi_cap, 32'h1234_5678);
        check("m3 sck idle high", {31'b0, spi_sck_o}, 32'd1);
        wb_read(1'b0, rd); check("m3 DATA", rd, 32'h1234_5678);

        // Busy write ignored: mode 0, presc 1 -> 36 busy cycles
        spi_cpol_i = 1'b0; spi_presc_i = 4'd1; miso_sel = 0;
        repeat (2) @(negedge clk_i);
        miso_byte = 8'h96; neg_base = neg_cnt; p0 = pos_cnt;
        wb_write(1'b0, 4'h0, 32'h0000_005A);
        repeat (6) @(negedge clk_i);
        check("busy rdy", {31'b0, spi_rdy_o}, 32'd0);
        wb_write(1'b0, 4'h0, 32'h0000_0011);
        wait_idle(extra);
        check("busy total cycles", 32'(6 + extra), 32'd36);
        check("busy pulses", 32'(pos_cnt - p0), 32'd8);
        check("busy mosi", {24'b0, mosi_cap[7:0]}, 32'h5A);
        wb_read(1'b0, rd); check("busy DATA", rd, 32'h0000_0096);

        // Reset mid-SHIFT
        spi_presc_i = 4'd2; miso_byte = 8'h00; neg_base = neg_cnt;
        @(negedge clk_i);
        wb_write(1'b0, 4'h0, 32'h0000_00FF);
        repeat (20) @(negedge clk_i);
        check("pre-reset mosi", {31'b0, spi_mosi_o}, 32'd1);
        rst_in = 1'b0;
        #1;
        check("midrst cs",   {31'b0, spi_cs_on},  32'd1);
        check("midrst sck",  {31'b0, spi_sck_o},  32'd0);
        check("midrst mosi", {31'b0, spi_mosi_o}, 32'd0);
        check("midrst rdy",  {31'b0, spi_rdy_o},  32'd1);
        wb_read(1'b0, rd); check("midrst DATA", rd, 32'h0);
        @(negedge clk_i);
        rst_in = 1'b1;
        spi_presc_i = 4'd0;
        @(negedge clk_i);

        // Manual CS across two transfers
        spi_auto_cs_i = 1'b0;
        wb_write(1'b1, 4'h1, 32'h1);
        check("manual cs low", {31'b0, spi_cs_on}, 32'd0);
        wb_read(1'b1, rd); check("CSCTRL cs", rd, 32'h1);
        wb_write(1'b1, 4'h0, 32'h0);
        wb_read(1'b1, rd); check("CSCTRL be0 off", rd, 32'h1);
        r0 = cs_rise_cnt;
        do_xfer(32'h0F, 8'hF0, cyc, pul);
        wb_read(1'b0, rd); check("man1 DATA", rd, 32'h0000_00F0);
        do_xfer(32'hF0, 8'h0F, cyc, pul);
        wb_read(1'b0, rd); check("man2 DATA", rd, 32'h0000_000F);
        check("man cs no rise", 32'(cs_rise_cnt - r0), 32'd0);
        check("man cs still low", {31'b0, spi_cs_on}, 32'd0);
        wb_write(1'b1, 4'h1, 32'h0);
        check("manual cs release", {31'b0, spi_cs_on}, 32'd1);
        spi_auto_cs_i = 1'b1;

        // Loopback configuration, MISO tied low
        miso_sel = 2;
        wb_write(1'b1, 4'h1, 32'h2);
        wb_read(1'b1, rd);
`ifdef SPI_MASTER_LOOPBACK_EN
        check("lb CSCTRL", rd, 32'h2);
`else
        check("lb CSCTRL", rd, 32'h0);
`endif
        do_xfer(32'hC3, 8'h00, cyc, pul);
        check("lb pulses", pul, 32'd8);
        wb_read(1'b0, rd);
`ifdef SPI_MASTER_LOOPBACK_EN
        check("lb DATA", rd, 32'h0000_00C3);
`else
        check("lb DATA", rd, 32'h0000_0000);
`endif
        wb_write(1'b1, 4'h1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
